// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD sequencer: FSM encodings, digit-correction
// constants and the elaboration-time digit-count helper.
package bcd_pkg;
  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Smallest digit count n with 10**n >= 2**bin_w.
  function automatic int digits_needed(input int bin_w);
    longint unsigned lim, p;
    int n;
    lim = 64'(1) << bin_w;
    p   = 64'(1);
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 64'(10);
        n++;
      end
    end
    return n;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// Combinational add-3 correction: every BCD digit >= 5 gets +3, digits are independent.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*DIGIT_W-1:0] acc_i,
  output logic [DIGITS*DIGIT_W-1:0] acc_o
);
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [DIGIT_W-1:0] d;
    assign d = acc_i[g*DIGIT_W +: DIGIT_W];
    assign acc_o[g*DIGIT_W +: DIGIT_W] = (d >= ADD3_THRESH) ? d + ADD3_VAL : d;
  end
endmodule

// File: rtl/bcd_seq_ctrl.sv
// Multi-cycle double-dabble binary-to-BCD sequencer with valid/ready on both sides.
// Optional feature macro BCD_NDIG_EN adds out_ndig (significant digit count).
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DIGITS-1:0]     out_bcd,
  output logic                    busy
`ifdef BCD_NDIG_EN
  ,
  output logic [3:0]              out_ndig
`endif
);
  localparam int AW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(BIN_W + 1);

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_w
    $error("bcd_seq_ctrl: BIN_W must be 1..32");
  end
  if (digits_needed(BIN_W) > DIGITS) begin : g_bad_dig
    $error("bcd_seq_ctrl: DIGITS too small for BIN_W");
  end

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    bcd_q, bcd_d;
  logic [AW-1:0]    acc_fix, acc_nxt;
  logic             accept, last_step;

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .acc_i (acc_q),
    .acc_o (acc_fix)
  );

  assign acc_nxt   = {acc_fix[AW-2:0], shreg_q[BIN_W-1]};
  assign last_step = (state_q == SHIFT) && (cnt_q == CW'(1));
  // Gated by rst_n so the block never advertises ready while held in reset.
  assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        acc_d   = acc_nxt;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (last_step) begin
          state_d = DONE;
          bcd_d   = acc_nxt;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Load overrides the DONE->IDLE transition for pass-through accepts.
    if (accept) begin
      state_d = SHIFT;
      shreg_d = in_bin;
      acc_d   = '0;
      cnt_d   = CW'(BIN_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign out_bcd   = bcd_q;

`ifdef BCD_NDIG_EN
  logic [3:0] ndig_q, ndig_d, ndig_c;

  always_comb begin
    ndig_c = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_nxt[i*DIGIT_W +: DIGIT_W] != '0) ndig_c = 4'(i + 1);
    end
  end

  always_comb begin
    ndig_d = ndig_q;
    if (last_step) ndig_d = ndig_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ndig_q <= '0;
    else        ndig_q <= ndig_d;
  end

  assign out_ndig = ndig_q;
`endif
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed and table-driven bench for bcd_seq_ctrl (BIN_W=16, DIGITS=5).
module tb_bcd_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_bin = '0;
  logic        in_ready, out_valid, busy;
  logic [19:0] out_bcd;
`ifdef BCD_NDIG_EN
  logic [3:0]  out_ndig;
`endif

  int errs = 0;
  int nchk = 0;

  bcd_seq_ctrl #(.BIN_W(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
`ifdef BCD_NDIG_EN
    ,
    .out_ndig  (out_ndig)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [3:0]  ndig;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_ndig(input int v);
    logic [3:0] n;
    int t;
    n = 4'd1;
    t = v;
    for (int i = 0; i < 5; i++) begin
      if (t % 10 != 0) n = 4'(i + 1);
      t = t / 10;
    end
    return n;
  endfunction

  // Accept v, then count edges until out_valid; lat = -1 on timeout.
  task automatic run_conv(input logic [15:0] v, output int lat);
    bit sh_ok;
    @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_bin   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat   = -1;
    sh_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (!busy || in_ready) sh_ok = 1'b0;
    end
    chk("shift_busy_noready", 32'(sh_ok), 32'd1);
    if (lat < 0) chk("conv_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int lat, gap;
    bit found;
    logic [15:0] rv;

    vecs[0] = '{16'd0,     20'h00000, 4'd1};
    vecs[1] = '{16'd65535, 20'h65535, 4'd5};
    vecs[2] = '{16'd9999,  20'h09999, 4'd4};
    vecs[3] = '{16'd10,    20'h00010, 4'd2};
    vecs[4] = '{16'd9,     20'h00009, 4'd1};
    vecs[5] = '{16'd100,   20'h00100, 4'd3};
    vecs[6] = '{16'd1,     20'h00001, 4'd1};
    vecs[7] = '{16'd12345, 20'h12345, 4'd5};
    vecs[8] = '{16'd999,   20'h00999, 4'd3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
`ifdef BCD_NDIG_EN
    chk("rst_ndig", 32'(out_ndig), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Table-driven conversions, out_ready tied high
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bin, lat);
      chk("tbl_latency", 32'(lat), 32'd16);
      chk("tbl_bcd", 32'(out_bcd), 32'(vecs[i].bcd));
`ifdef BCD_NDIG_EN
      chk("tbl_ndig", 32'(out_ndig), 32'(vecs[i].ndig));
`endif
    end

    // Output stall: result held 20 cycles, no capture of in_valid meanwhile
    @(posedge clk);
    #1 out_ready = 1'b0;
    run_conv(16'd2024, lat);
    chk("stall_latency", 32'(lat), 32'd16);
    chk("stall_first_bcd", 32'(out_bcd), 32'h02024);
    in_valid = 1'b1;
    in_bin   = 16'd77;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_bcd", 32'(out_bcd), 32'h02024);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_valid_low", 32'(out_valid), 32'd0);
    chk("handoff_bcd_kept", 32'(out_bcd), 32'h02024);
    chk("handoff_idle_ready", 32'(in_ready), 32'd1);
    chk("handoff_not_busy", 32'(busy), 32'd0);

    // Back-to-back with pass-through accept: 1,2,3
    @(negedge clk);
    in_bin   = 16'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_bin = 16'd2;
    gap = 0;
    for (int i = 0; i < 3; i++) begin
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(posedge clk);
        #1;
        gap++;
        if (out_valid) found = 1'b1;
      end
      chk("tp_found", 32'(found), 32'd1);
      chk("tp_bcd", 32'(out_bcd), 32'(i + 1));
      chk("tp_gap", 32'(gap), (i == 0) ? 32'd16 : 32'd17);
      if (i < 2) begin
        chk("tp_passthru_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("tp_reaccept_busy", 32'(busy), 32'd1);
        in_bin = 16'(i + 3);
        if (i == 1) in_valid = 1'b0;
        gap = 1;
      end
    end

    // Reset mid-conversion
    @(posedge clk);
    @(negedge clk);
    in_bin   = 16'd1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(out_bcd), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
`ifdef BCD_NDIG_EN
    chk("abort_ndig", 32'(out_ndig), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(16'd4321, lat);
    chk("after_abort_lat", 32'(lat), 32'd16);
    chk("after_abort_bcd", 32'(out_bcd), 32'h04321);

    // Random sweep against a divide/modulo reference
    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, lat);
      chk("rnd_latency", 32'(lat), 32'd16);
      chk("rnd_bcd", 32'(out_bcd), 32'(ref_bcd(int'(rv))));
`ifdef BCD_NDIG_EN
      chk("rnd_ndig", 32'(out_ndig), 32'(ref_ndig(int'(rv))));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
